// File: rtl/prince_pkg.sv
// Shared definitions for the PRINCE round controller: step encodings,
// round-constant seeds and schedule landmarks.
package prince_pkg;

    localparam int SBOX_LAT_DEFAULT = 2;

    // Step indices within the 25-step schedule.
    localparam int MID_STEP     = 12;
    localparam int ADD_OUT_STEP = 24;

    localparam logic [63:0] ALPHA = 64'hc0ac29b7c97c50dd;

    typedef enum logic [2:0] {
        LIN_NONE    = 3'd0,
        LIN_ADD_IN  = 3'd1,
        LIN_FWD     = 3'd2,
        LIN_MID     = 3'd3,
        LIN_BWD     = 3'd4,
        LIN_ADD_OUT = 3'd5
    } lin_sel_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADD,
        ST_SBOX,
        ST_LIN,
        ST_DONE
    } ctrl_state_e;

    // RC0..RC5; RC6..RC11 follow from RC[11-i] = RC[i] ^ ALPHA.
    localparam logic [63:0] RC_LO [6] = '{
        64'h0000000000000000,
        64'h13198a2e03707344,
        64'ha4093822299f31d0,
        64'h082efa98ec4e6c89,
        64'h452821e638d01377,
        64'hbe5466cf34e90c6c
    };

    // Kind of linear step found at a given schedule index (LIN state only).
    function automatic lin_sel_e lin_step_kind(input logic [4:0] step);
        if (step == 5'(MID_STEP))
            return LIN_MID;
        else if (step == 5'(ADD_OUT_STEP))
            return LIN_ADD_OUT;
        else if (step < 5'(MID_STEP))
            return LIN_FWD;
        else
            return LIN_BWD;
    endfunction

endpackage

// File: rtl/prince_rc_rom.sv
// Combinational PRINCE round-constant lookup, RC0..RC11 indexed by round.
module prince_rc_rom
    import prince_pkg::*;
(
    input  logic [3:0]  round,
    output logic [63:0] rc
);

    // Upper half is mirrored from the lower half, so the alpha-reflection holds by construction.
    always_comb begin
        rc = '0;
        for (int i = 0; i < 6; i++) begin
            if (round == 4'(i))
                rc = RC_LO[i];
            if (round == 4'(11 - i))
                rc = RC_LO[i] ^ ALPHA;
        end
    end

endmodule

// File: rtl/prince_round_ctrl.sv
// Control sequencer for a masked PRINCE datapath: walks the 25-step
// schedule and drives state write, S-box pipeline, key/RC and handshake.
module prince_round_ctrl
    import prince_pkg::*;
#(
    parameter int SBOX_LAT = SBOX_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        state_we,
    output logic        load_in,
    output logic        sbox_en,
    output logic        sbox_inv,
    output logic        rnd_req,
    output logic [2:0]  lin_sel,
    output logic [63:0] rc,
    output logic [3:0]  round
);

    localparam logic [2:0] LAST_CYC = 3'(SBOX_LAT - 1);

    ctrl_state_e state_reg, state_next;
    logic [4:0]  step_reg, step_next;
    logic [2:0]  cyc_reg, cyc_next;
    logic [3:0]  round_reg, round_next;
    lin_sel_e    lin_sel_int;
    logic [63:0] rom_rc;

    prince_rc_rom u_rc_rom (
        .round (round_reg),
        .rc    (rom_rc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            step_reg  <= '0;
            cyc_reg   <= '0;
            round_reg <= '0;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
            cyc_reg   <= cyc_next;
            round_reg <= round_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        step_next   = step_reg;
        cyc_next    = cyc_reg;
        round_next  = round_reg;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        state_we    = 1'b0;
        load_in     = 1'b0;
        sbox_en     = 1'b0;
        sbox_inv    = 1'b0;
        rnd_req     = 1'b0;
        lin_sel_int = LIN_NONE;

        case (state_reg)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (start) begin
                    state_next = ST_ADD;
                    step_next  = '0;
                    cyc_next   = '0;
                    round_next = '0;
                end
            end
            ST_ADD: begin
                state_we    = 1'b1;
                load_in     = 1'b1;
                lin_sel_int = LIN_ADD_IN;
                state_next  = ST_SBOX;
                step_next   = 5'd1;
                round_next  = 4'd1;
            end
            ST_SBOX: begin
                sbox_en  = 1'b1;
                sbox_inv = (step_reg > 5'(MID_STEP));
                rnd_req  = (cyc_reg == 3'd0);
                if (cyc_reg == LAST_CYC) begin
                    state_we   = 1'b1;
                    cyc_next   = '0;
                    step_next  = step_reg + 5'd1;
                    state_next = ST_LIN;
                end else begin
                    cyc_next = cyc_reg + 3'd1;
                end
            end
            ST_LIN: begin
                state_we    = 1'b1;
                lin_sel_int = lin_step_kind(step_reg);
                if (step_reg == 5'(ADD_OUT_STEP)) begin
                    state_next = ST_DONE;
                end else begin
                    step_next  = step_reg + 5'd1;
                    state_next = ST_SBOX;
                    // MID shares its round with the S layers on either side.
                    if (lin_sel_int != LIN_MID)
                        round_next = round_reg + 4'd1;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_IDLE;
                    step_next  = '0;
                    round_next = '0;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign lin_sel = lin_sel_int;
    assign round   = round_reg;
    assign rc      = (lin_sel_int == LIN_NONE || lin_sel_int == LIN_MID) ? 64'd0 : rom_rc;

endmodule

// File: tb/tb_prince_round_ctrl.sv
// Self-checking bench for prince_round_ctrl: schedule-trace model with
// per-cycle compare, directed scenarios and randomized handshakes.
module tb_prince_round_ctrl;

    localparam int L = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic start = 1'b0, out_ready = 1'b0;
    logic start1 = 1'b0, start7 = 1'b0, ready_hi = 1'b1;

    logic        in_ready, out_valid, state_we, load_in, sbox_en, sbox_inv, rnd_req;
    logic [2:0]  lin_sel;
    logic [63:0] rc;
    logic [3:0]  round;

    logic        ir1, ov1, we1, ld1, se1, si1, rr1;
    logic [2:0]  ls1;
    logic [63:0] rc1;
    logic [3:0]  rd1;
    logic        ir7, ov7, we7, ld7, se7, si7, rr7;
    logic [2:0]  ls7;
    logic [63:0] rc7;
    logic [3:0]  rd7;

    prince_round_ctrl #(.SBOX_LAT(2)) dut (
        .clk(clk), .rst(rst), .start(start), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .state_we(state_we), .load_in(load_in), .sbox_en(sbox_en),
        .sbox_inv(sbox_inv), .rnd_req(rnd_req), .lin_sel(lin_sel), .rc(rc), .round(round)
    );
    prince_round_ctrl #(.SBOX_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .in_ready(ir1), .out_valid(ov1),
        .out_ready(ready_hi), .state_we(we1), .load_in(ld1), .sbox_en(se1),
        .sbox_inv(si1), .rnd_req(rr1), .lin_sel(ls1), .rc(rc1), .round(rd1)
    );
    prince_round_ctrl #(.SBOX_LAT(7)) dut7 (
        .clk(clk), .rst(rst), .start(start7), .in_ready(ir7), .out_valid(ov7),
        .out_ready(ready_hi), .state_we(we7), .load_in(ld7), .sbox_en(se7),
        .sbox_inv(si7), .rnd_req(rr7), .lin_sel(ls7), .rc(rc7), .round(rd7)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [77:0] pack(input logic ir, input logic ov, input logic we,
                                         input logic ld, input logic sb, input logic inv,
                                         input logic rr, input logic [2:0] ls,
                                         input logic [3:0] rd, input logic [63:0] r);
        return {ir, ov, we, ld, sb, inv, rr, ls, rd, r};
    endfunction

    // Reference schedule: one entry per busy cycle, built from the step list.
    logic [63:0] rc_ref [12];
    logic [77:0] trace [$];

    task automatic push_s(input logic inv, input int rd);
        for (int c = 0; c < L; c++)
            trace.push_back(pack(1'b0, 1'b0, c == L - 1, 1'b0, 1'b1, inv, c == 0, 3'd0, 4'(rd), 64'd0));
    endtask

    task automatic push_lin(input int ls, input int rd);
        logic [63:0] r;
        r = (ls == 3) ? 64'd0 : rc_ref[rd];
        trace.push_back(pack(1'b0, 1'b0, 1'b1, ls == 1, 1'b0, 1'b0, 1'b0, 3'(ls), 4'(rd), r));
    endtask

    int m_mode = 0;   // 0 idle, 1 busy, 2 done
    int m_pos  = 0;
    logic chk_on = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode <= 0;
            m_pos  <= 0;
        end else begin
            case (m_mode)
                0: if (start) begin m_mode <= 1; m_pos <= 0; end
                1: begin
                    m_pos <= m_pos + 1;
                    if (m_pos + 1 == trace.size()) m_mode <= 2;
                end
                default: if (out_ready) m_mode <= 0;
            endcase
        end
    end

    function automatic logic [77:0] model_out();
        if (m_mode == 1 && m_pos < trace.size())
            return trace[m_pos];
        else if (m_mode == 2)
            return pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd11, 64'd0);
        else
            return pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 64'd0);
    endfunction

    always @(negedge clk) begin
        if (chk_on)
            check("ctrl_outputs",
                  128'({in_ready, out_valid, state_we, load_in, sbox_en, sbox_inv, rnd_req, lin_sel, round, rc}),
                  128'(model_out()));
    end

    int cyc = 0;
    int we_cnt = 0, rnd_cnt = 0;
    logic [63:0] rc_seq [$];
    int accepts [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (state_we) we_cnt <= we_cnt + 1;
        if (rnd_req)  rnd_cnt <= rnd_cnt + 1;
        if (lin_sel != 3'd0) rc_seq.push_back(rc);
        if (in_ready && start) accepts.push_back(cyc);
    end

    function automatic logic sel_ov(input int w);
        if (w == 1) return ov1;
        if (w == 7) return ov7;
        return out_valid;
    endfunction

    // Pulse start on the chosen instance and count edges until out_valid.
    task automatic run_latency(input int which, output int lat);
        @(negedge clk); #1;
        case (which)
            1: start1 = 1'b1;
            7: start7 = 1'b1;
            default: start = 1'b1;
        endcase
        @(posedge clk); #1;
        start = 1'b0; start1 = 1'b0; start7 = 1'b0;
        lat = 0;
        while (!sel_ov(which) && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat, we0, rnd0, w;
        logic [63:0] exp_rc [13];

        rc_ref[0]  = 64'h0000000000000000;
        rc_ref[1]  = 64'h13198a2e03707344;
        rc_ref[2]  = 64'ha4093822299f31d0;
        rc_ref[3]  = 64'h082efa98ec4e6c89;
        rc_ref[4]  = 64'h452821e638d01377;
        rc_ref[5]  = 64'hbe5466cf34e90c6c;
        rc_ref[6]  = 64'h7ef84f78fd955cb1;
        rc_ref[7]  = 64'h85840851f1ac43aa;
        rc_ref[8]  = 64'hc882d32f25323c54;
        rc_ref[9]  = 64'h64a51195e0e3610d;
        rc_ref[10] = 64'hd3b5a399ca0c2399;
        rc_ref[11] = 64'hc0ac29b7c97c50dd;
        for (int i = 0; i < 6; i++) exp_rc[i] = rc_ref[i];
        exp_rc[6] = 64'd0;
        for (int i = 6; i < 12; i++) exp_rc[i + 1] = rc_ref[i];

        push_lin(1, 0);
        for (int i = 1; i <= 5; i++) begin push_s(1'b0, i); push_lin(2, i); end
        push_s(1'b0, 6); push_lin(3, 6); push_s(1'b1, 6);
        for (int i = 6; i <= 10; i++) begin push_lin(4, i); push_s(1'b1, i + 1); end
        push_lin(5, 11);

        #2 rst = 1'b1;
        #1 chk_on = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        check("reset_in_ready", 128'(in_ready), 128'(1));
        check("reset_idle_ctrl", 128'({out_valid, state_we, load_in, sbox_en, rnd_req, lin_sel, round, rc}), 128'(0));
        check("trace_len", 128'(trace.size()), 128'(37));

        // Single encryption, consumer stalls afterwards.
        we0 = we_cnt; rnd0 = rnd_cnt; rc_seq.delete();
        run_latency(2, lat);
        check("latency_L2", 128'(lat), 128'(37));
        check("state_we_pulses", 128'(we_cnt - we0), 128'(25));
        check("rnd_req_pulses", 128'(rnd_cnt - rnd0), 128'(12));
        check("rc_seq_len", 128'(rc_seq.size()), 128'(13));
        for (int i = 0; i < 13 && i < rc_seq.size(); i++)
            check($sformatf("rc_seq[%0d]", i), 128'(rc_seq[i]), 128'(exp_rc[i]));
        if (rc_seq.size() >= 13) begin
            check("rc_round1", 128'(rc_seq[1]), 128'(64'h13198a2e03707344));
            check("rc_mirror", 128'(rc_seq[0] ^ rc_seq[12]), 128'(64'hc0ac29b7c97c50dd));
        end

        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("hold_done", 128'({out_valid, in_ready, state_we, sbox_en}), 128'(4'b1000));
            #1;
            start = (k == 3);
        end
        @(negedge clk); #1 start = 1'b0; out_ready = 1'b1;
        @(negedge clk); #1 out_ready = 1'b0;
        check("back_to_idle", 128'(in_ready), 128'(1));

        // Asynchronous reset mid-encryption.
        @(negedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk); #1 rst = 1'b1;
        #1 check("rst_mid", 128'({in_ready, out_valid, state_we, sbox_en, rnd_req, round}), 128'(9'b1_0000_0000));
        @(negedge clk); #1 rst = 1'b0;
        run_latency(2, lat);
        check("latency_after_rst", 128'(lat), 128'(37));

        // Back-to-back with start held high.
        @(negedge clk); #1 accepts.delete(); out_ready = 1'b1; start = 1'b1;
        repeat (130) @(posedge clk);
        #1 start = 1'b0;
        w = 0;
        while (!in_ready && w < 300) begin @(posedge clk); #1; w++; end
        check("b2b_accepts", 128'(accepts.size() >= 3), 128'(1));
        for (int i = 1; i < 3 && i < accepts.size(); i++)
            check("b2b_gap", 128'(accepts[i] - accepts[i - 1]), 128'(39));

        // Randomized start / out_ready / reset.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk); #1;
            start     = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 2) == 0);
            rst       = ($urandom_range(0, 399) == 0);
        end
        @(negedge clk); #1 rst = 1'b0; start = 1'b0; out_ready = 1'b1;
        w = 0;
        while (!in_ready && w < 300) begin @(posedge clk); #1; w++; end
        check("drain_idle", 128'(in_ready), 128'(1));

        // Other pipeline depths.
        run_latency(1, lat);
        check("latency_L1", 128'(lat), 128'(25));
        run_latency(7, lat);
        check("latency_L7", 128'(lat), 128'(97));
        repeat (3) @(negedge clk);
        check("l1_idle", 128'({ir1, ov1, we1, ld1, se1, si1, rr1, ls1, rd1, rc1}), 128'({1'b1, 77'd0}));
        check("l7_idle", 128'({ir7, ov7, we7, ld7, se7, si7, rr7, ls7, rd7, rc7}), 128'({1'b1, 77'd0}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
